// File: rtl/ntt_pkg.sv
// Shared types and default geometry for the NTT result path.
// The unloader modules take their parameter defaults from this package.
package ntt_pkg;

  localparam int DEF_LOG_CORE_COUNT = 5;
  localparam int DEF_DATA_WIDTH     = 60;
  localparam int DEF_ADDR_WIDTH     = 9;

  localparam int NTT_N     = 1 << DEF_LOG_CORE_COUNT;
  localparam int NTT_D     = 1 << DEF_ADDR_WIDTH;
  localparam int NTT_IDX_W = DEF_ADDR_WIDTH + DEF_LOG_CORE_COUNT + 1;

  typedef logic [DEF_DATA_WIDTH-1:0] ntt_word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } ntt_state_t;

  // Coefficient index is {addr, core, lane}.
  function automatic int index_width(input int log_cores, input int addr_width);
    return addr_width + log_cores + 1;
  endfunction

endpackage

// File: rtl/ntt_result_bank.sv
// One result bank: simple dual-port RAM, one write port and one registered read port.
// Contents are deliberately not reset.
module ntt_result_bank #(
  parameter int DATA_WIDTH = 60,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [(1 << ADDR_WIDTH)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_result_unloader.sv
// Captures one full transform from the per-core result lanes into banked RAM, then
// streams it out in natural coefficient order through a 2-entry skid FIFO.
module ntt_result_unloader
  import ntt_pkg::*;
#(
  parameter int LOG_CORE_COUNT = DEF_LOG_CORE_COUNT,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  localparam int NUM_CORES     = 1 << LOG_CORE_COUNT,
  localparam int IDX_W         = index_width(LOG_CORE_COUNT, ADDR_WIDTH)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   in_valid,
  input  logic [NUM_CORES-1:0][1:0][DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CORES-1:0][ADDR_WIDTH-1:0]   in_addr,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [DATA_WIDTH-1:0]                  m_data,
  output logic [IDX_W-1:0]                       m_index,
  output logic                                   m_last,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   overrun,
  output logic [1:0]                             dbg_state
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  ntt_state_t state_q, state_d;

  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  cap_we;
  logic                  beat_last;
  logic [IDX_W-1:0]      rd_idx_q;
  logic                  rd_all_q;
  logic                  rd_issue;
  logic                  rd_valid_q;
  logic [IDX_W-1:0]      rd_idx_p_q;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [2:0]            committed;
  logic [1:0]            fifo_cnt_q;
  logic [DATA_WIDTH-1:0] tail_data_q;
  logic [IDX_W-1:0]      tail_idx_q;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push;
  logic                  pop;
  logic                  last_pop;
  logic                  done_q;
  logic                  overrun_q;
  logic [DATA_WIDTH-1:0] bank_q [NUM_CORES][2];

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    for (genvar l = 0; l < 2; l++) begin : g_lane
      ntt_result_bank #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
      ) u_bank (
        .clk  (clk),
        .we   (cap_we),
        .waddr(in_addr[k]),
        .wdata(in_data[k][l]),
        .raddr(rd_addr),
        .rdata(bank_q[k][l])
      );
    end
  end

  assign cap_we    = (state_q == CAPTURE) && in_valid;
  assign beat_last = cap_we && (beat_cnt_q == CNT_W'(DEPTH - 1));
  assign rd_addr   = rd_idx_q[IDX_W-1 -: ADDR_WIDTH];

  // Output handshake: a word transfers on a rising edge where m_valid & m_ready are both
  // high; while m_valid & !m_ready the word, index and last flag are held unchanged.
  assign m_valid  = (fifo_cnt_q != 2'd0);
  assign pop      = m_valid && m_ready;
  assign last_pop = pop && m_last;
  assign push     = rd_valid_q;
  assign push_data = bank_q[rd_idx_p_q[LOG_CORE_COUNT:1]][rd_idx_p_q[0]];

  // Words already stored plus the one in the bank pipeline must never exceed two.
  assign committed = {1'b0, fifo_cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop};
  assign rd_issue  = (state_q == DRAIN) && !rd_all_q && (committed < 3'd2);

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: if (beat_last) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q  <= '0;
      rd_idx_q    <= '0;
      rd_all_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_idx_p_q  <= '0;
      fifo_cnt_q  <= 2'd0;
      m_data      <= '0;
      m_index     <= '0;
      m_last      <= 1'b0;
      tail_data_q <= '0;
      tail_idx_q  <= '0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      done_q <= last_pop;

      // A stray beat outranks the clear from start in the same cycle.
      if (in_valid && (state_q != CAPTURE))  overrun_q <= 1'b1;
      else if ((state_q == IDLE) && start)   overrun_q <= 1'b0;

      if ((state_q == IDLE) && start) beat_cnt_q <= '0;
      else if (cap_we)                beat_cnt_q <= beat_cnt_q + 1'b1;

      if (state_q != DRAIN) begin
        rd_idx_q <= '0;
        rd_all_q <= 1'b0;
      end else if (rd_issue) begin
        rd_idx_q <= rd_idx_q + 1'b1;
        if (&rd_idx_q) rd_all_q <= 1'b1;
      end

      rd_valid_q <= rd_issue;
      if (rd_issue) rd_idx_p_q <= rd_idx_q;

      case (fifo_cnt_q)
        2'd0: begin
          if (push) begin
            m_data     <= push_data;
            m_index    <= rd_idx_p_q;
            m_last     <= &rd_idx_p_q;
            fifo_cnt_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            m_data  <= push_data;
            m_index <= rd_idx_p_q;
            m_last  <= &rd_idx_p_q;
          end else if (push) begin
            tail_data_q <= push_data;
            tail_idx_q  <= rd_idx_p_q;
            fifo_cnt_q  <= 2'd2;
          end else if (pop) begin
            fifo_cnt_q <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            m_data  <= tail_data_q;
            m_index <= tail_idx_q;
            m_last  <= &tail_idx_q;
            if (push) begin
              tail_data_q <= push_data;
              tail_idx_q  <= rd_idx_p_q;
            end else begin
              fifo_cnt_q <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_result_unloader.sv
// Bench for ntt_result_unloader in a 2-core, depth-4 configuration: randomized captures
// against a coefficient-array model, with a decoupled output monitor.
module tb_ntt_result_unloader;

  localparam int LOGC  = 1;
  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int NC    = 2;
  localparam int DEP   = 4;
  localparam int IW    = 4;
  localparam int WORDS = 16;
  localparam int EW    = 1 + IW + DW;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic                     in_valid;
  logic [NC-1:0][1:0][DW-1:0] in_data;
  logic [NC-1:0][AW-1:0]    in_addr;
  logic                     m_valid;
  logic                     m_ready;
  logic [DW-1:0]            m_data;
  logic [IW-1:0]            m_index;
  logic                     m_last;
  logic                     busy;
  logic                     done;
  logic                     overrun;
  logic [1:0]               dbg_state;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model [NC][2][DEP];
  int ready_mode = 0;
  int done_cnt = 0;
  bit exp_done_next = 0;
  bit exp_overrun = 0;
  int run_tag = 0;

  ntt_result_unloader #(
    .LOG_CORE_COUNT(LOGC),
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_addr  (in_addr),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_index  (m_index),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive_random_beat();
    for (int k = 0; k < NC; k++) begin
      in_addr[k] = AW'($urandom_range(0, DEP - 1));
      for (int l = 0; l < 2; l++) in_data[k][l] = DW'($urandom);
    end
    in_valid = 1'b1;
  endtask

  // sink ready driver
  initial begin
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int rc = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = pat[rc % 4]; rc++; end
        default: m_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // output monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_done_next = 0;
      end else begin
        if (exp_done_next) begin
          chk("done_pulse", done, 1);
          chk("idle_after_done", busy, 0);
          done_cnt++;
        end else if (done) begin
          chk("done_spurious", done, 0);
        end
        exp_done_next = 0;
        if (m_valid) begin
          if (exp_q.size() == 0) begin
            chk("word_without_expect", m_valid, 0);
          end else begin
            chk("word", {m_last, m_index, m_data}, exp_q[0]);
            if (m_ready) begin
              if (exp_q[0][EW-1]) exp_done_next = 1;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic run_capture(input int addr_mode, input int rmode, input bit start_valid,
                             input bit drain_valid, input bit drain_start);
    int dc0;
    logic [AW-1:0] a;
    int perm[4];
    perm = '{3, 1, 0, 2};
    run_tag++;
    ready_mode = rmode;
    dc0 = done_cnt;
    start = 1'b1;
    if (start_valid) begin
      drive_random_beat();
      exp_overrun = 1;
    end else begin
      exp_overrun = 0;
    end
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    chk("busy_capture", busy, 1);
    chk("overrun_after_start", overrun, exp_overrun);

    for (int b = 0; b < DEP; b++) begin
      if (addr_mode == 2 && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      for (int k = 0; k < NC; k++) begin
        case (addr_mode)
          0:       a = AW'(b);
          1:       a = AW'(perm[(b + k) % 4]);
          default: a = AW'($urandom_range(0, DEP - 1));
        endcase
        in_addr[k] = a;
        for (int l = 0; l < 2; l++) begin
          if (addr_mode == 2) in_data[k][l] = DW'($urandom);
          else                in_data[k][l] = {8'(run_tag), 4'(k), 2'(l), a};
          model[k][l][a] = in_data[k][l];
        end
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end

    // first cycle of the drain phase: queue the whole transform in natural order
    for (int i = 0; i < WORDS; i++)
      exp_q.push_back({(i == WORDS - 1), IW'(i), model[(i >> 1) & 1][i & 1][i >> 2]});
    chk("drain_busy", busy, 1);
    chk("lat_c0", m_valid, 0);
    if (drain_valid) begin
      drive_random_beat();
      exp_overrun = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_c1", m_valid, 0);
    if (drain_start) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("lat_c2", m_valid, 1);

    for (int c = 0; c < 600 && done_cnt == dc0; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("done_once", done_cnt - dc0, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    chk("overrun_end", overrun, exp_overrun);
    exp_q.delete();
  endtask

  task automatic run_abort();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < NC; k++) begin
        in_addr[k] = AW'(b);
        for (int l = 0; l < 2; l++) begin
          in_data[k][l] = DW'($urandom);
          model[k][l][b] = in_data[k][l];
        end
      end
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_overrun = 0;
    chk("abort_busy", busy, 0);
    chk("abort_mvalid", m_valid, 0);
    chk("abort_state", dbg_state, 0);
    chk("abort_overrun", overrun, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_index", m_index, 0);

    // stray beat while idle, then a normal run clears it
    drive_random_beat();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("overrun_idle", overrun, 1);

    run_capture(0, 0, 0, 0, 0);
    run_capture(0, 1, 0, 0, 0);
    run_capture(1, 0, 0, 0, 0);
    run_capture(0, 2, 0, 1, 0);
    run_abort();
    run_capture(1, 2, 0, 0, 0);
    run_capture(0, 0, 0, 0, 1);
    run_capture(0, 1, 1, 0, 0);
    for (int r = 0; r < 6; r++)
      run_capture(2, 2, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
